ram_4kx4: RTL and testbench

//   Single-port 4096 x 4-bit static RAM with a shared bidirectional (tri-state) data bus.

---
 rtl/ram_pkg.sv | 24 ++
 rtl/ram_4kx4_if.sv | 27 ++
 rtl/ram_core.sv | 34 +++
 rtl/ram_4kx4.sv | 106 ++++++++++
 tb/tb_ram_4kx4.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared constants, types and state encoding for the 4K x 4 scratch RAM.
// RAM_INIT_CLEAR_EN selects the post-reset zero-fill sweep; ST_CLEAR/ST_READY are used only when it is defined.
package ram_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // Write request presented to the storage array.
    typedef struct packed {
        logic  we;
        addr_t addr;
        data_t wdata;
    } wr_req_t;

endpackage

// File: rtl/ram_4kx4_if.sv
// Control/address side of the RAM bus; the tri-state data bus stays a plain inout port.
interface ram_4kx4_if;
    import ram_pkg::*;

    logic  cs;
    logic  we;
    addr_t dir;
    logic  ready;
    logic  drive_c;

    modport master (
        output cs,
        output we,
        output dir,
        input  ready,
        input  drive_c
    );

    modport slave (
        input  cs,
        input  we,
        input  dir,
        output ready,
        output drive_c
    );

endinterface

// File: rtl/ram_core.sv
// DEPTH x DATA_W storage array: synchronous write port and registered read port.
module ram_core
    import ram_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we_i,
    input  logic  re_i,
    input  addr_t addr_i,
    input  data_t wdata_i,
    output data_t rdata_o
);

    data_t mem [DEPTH];
    data_t rd_q;

    // Array contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem[addr_i];
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/ram_4kx4.sv
// 4096 x 4 single-port RAM with a shared tri-state data bus.
// Define RAM_INIT_CLEAR_EN to zero-fill the array after every reset before accepting accesses.
module ram_4kx4
    import ram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    ram_4kx4_if.slave        bus,
    inout  wire [DATA_W-1:0] data
);

    logic    ready_q;
    logic    bus_rd;
    logic    bus_wr;
    logic    drive;
    logic    sweeping;
    addr_t   sweep_addr;
    wr_req_t req;
    data_t   rdata;

    // An X/Z on cs or we fails both conditions, so it decodes as idle.
    always_comb begin
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        if (bus.cs && bus.we) begin
            bus_wr = ready_q;
        end
        if (bus.cs && !bus.we) begin
            bus_rd = ready_q;
        end
    end

`ifdef RAM_INIT_CLEAR_EN
    state_t state_q;
    addr_t  clr_addr_q;

    // Zero-fill sweep: one word per cycle, then hand the array to the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    clr_addr_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sweeping   = (state_q == ST_CLEAR) && rst_n;
    assign sweep_addr = clr_addr_q;
`else
    // Without the sweep the array is usable from the first cycle out of reset.
    always_ff @(posedge clk) begin
        ready_q <= 1'b1;
    end

    assign sweeping   = 1'b0;
    assign sweep_addr = '0;
`endif

    // Write mux: the sweep owns the array port while it runs.
    always_comb begin
        req = '0;
        if (sweeping) begin
            req.we    = 1'b1;
            req.addr  = sweep_addr;
            req.wdata = '0;
        end else begin
            req.we    = bus_wr && rst_n;
            req.addr  = bus.dir;
            req.wdata = data;
        end
    end

    ram_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (req.we),
        .re_i    (bus_rd && !sweeping),
        .addr_i  (req.addr),
        .wdata_i (req.wdata),
        .rdata_o (rdata)
    );

    // Combinational enable so the bus is released in the same cycle cs falls or we rises.
    assign drive       = bus_rd && rst_n;
    assign data        = drive ? rdata : 'z;
    assign bus.drive_c = drive;
    assign bus.ready   = ready_q;

endmodule

// File: tb/tb_ram_4kx4.sv
// Self-checking bench for ram_4kx4: directed table, hand-written reset/sweep sequences, random traffic vs. a word model.
module tb_ram_4kx4;
    import ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_4kx4_if bus ();
    logic             mdrive;
    data_t            mdata;
    wire [DATA_W-1:0] data;
    assign data = mdrive ? mdata : 'z;

    ram_4kx4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .data  (data)
    );

`ifdef RAM_INIT_CLEAR_EN
    localparam bit INIT = 1'b1;
`else
    localparam bit INIT = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: words written so far; in the init build unwritten words are zero.
    data_t model [int];

    typedef struct {
        logic  cs;
        logic  we;
        addr_t dir;
        data_t wdata;
        logic  mdrv;
        logic  exp_drive;
        logic  chk_data;
        data_t exp_data;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus(input logic cs, input logic we, input addr_t dir,
                             input data_t md, input logic mdrv);
        bus.cs  = cs;
        bus.we  = we;
        bus.dir = dir;
        mdata   = md;
        mdrive  = mdrv;
    endtask

    // Called right after rst_n is released; counts edges until ready is seen high.
    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check(name, n, 4096);
    endtask

    function automatic logic known(input addr_t a);
        return model.exists(int'(a)) || INIT;
    endfunction

    function automatic data_t lookup(input addr_t a);
        if (model.exists(int'(a))) return model[int'(a)];
        return '0;
    endfunction

    initial begin
        drive_bus(1'b1, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;

        // Reset: bus released, ready per build, read register cleared.
        tick();
        tick();
        check("reset_drive", int'(bus.drive_c), 0);
        check("reset_ready", int'(bus.ready), INIT ? 0 : 1);
        check("reset_rd_q", int'(dut.u_core.rd_q), 0);
        drive_bus(1'b0, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;

        if (INIT) begin
            wait_ready("init_sweep_len");
            drive_bus(1'b1, 1'b0, 12'hABC, '0, 1'b0);
            tick();
            check("init_read_abc", int'(data), 0);
            check("init_read_drive", int'(bus.drive_c), 1);
        end else begin
            check("noinit_ready", int'(bus.ready), 1);
        end

        // Directed table: write/read corners, turnaround, idle write.
        vecs.push_back('{1'b1, 1'b1, 12'h000, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b1, 12'hFFF, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA});
        vecs.push_back('{1'b1, 1'b0, 12'hFFF, 4'h0, 1'b0, 1'b1, 1'b1, 4'h5});
        vecs.push_back('{1'b1, 1'b1, 12'h123, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 12'h123, 4'h0, 1'b0, 1'b1, 1'b1, 4'h3});
        vecs.push_back('{1'b0, 1'b0, 12'h123, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 12'h000, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA});
        vecs.push_back('{1'b0, 1'b1, 12'hFFF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 12'hFFF, 4'h0, 1'b0, 1'b1, 1'b1, 4'h5});

        foreach (vecs[i]) begin
            drive_bus(vecs[i].cs, vecs[i].we, vecs[i].dir, vecs[i].wdata, vecs[i].mdrv);
            #1;
            check($sformatf("tbl%0d_drive", i), int'(bus.drive_c), int'(vecs[i].exp_drive));
            tick();
            if (vecs[i].chk_data) begin
                check($sformatf("tbl%0d_data", i), int'(data), int'(vecs[i].exp_data));
            end
        end
        model[12'h000] = 4'hA;
        model[12'hFFF] = 4'h5;
        model[12'h123] = 4'h3;

        // Random traffic against the word model.
        for (int k = 0; k < 400; k++) begin
            logic  cs;
            logic  we;
            addr_t a;
            data_t md;
            int    r;
            cs = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 7);
            a  = (r == 0) ? 12'hFFF : (r == 1) ? 12'h000 : ADDR_W'($urandom_range(0, 31));
            md = DATA_W'($urandom);
            drive_bus(cs, we, a, md, we);
            #1;
            check("rnd_drive", int'(bus.drive_c), int'(cs && !we));
            tick();
            if (cs && we) begin
                model[int'(a)] = md;
            end else if (cs && known(a)) begin
                check($sformatf("rnd_data@%0h", a), int'(data), int'(lookup(a)));
            end
        end

        if (INIT) begin
            // Reset mid-sweep with the master hammering a write that must be ignored.
            drive_bus(1'b1, 1'b1, 12'hABC, 4'hF, 1'b1);
            rst_n = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
            for (int c = 0; c < 100; c++) tick();
            check("sweep_busy_ready", int'(bus.ready), 0);
            check("sweep_busy_drive", int'(bus.drive_c), 0);
            rst_n = 1'b0;
            tick();
            check("abort_ready", int'(bus.ready), 0);
            tick();
            rst_n = 1'b1;
            wait_ready("resweep_len");
            drive_bus(1'b0, 1'b0, '0, '0, 1'b0);
            model.delete();
            for (int a = 0; a < int'(DEPTH); a++) begin
                drive_bus(1'b1, 1'b0, ADDR_W'(a), '0, 1'b0);
                tick();
                if (data !== '0 || a == 0 || a == int'(DEPTH - 1) || a == 12'hABC) begin
                    check($sformatf("clear@%0h", a), int'(data), 0);
                end
            end
        end

        // Release in the same cycle cs falls.
        drive_bus(1'b1, 1'b0, 12'h000, '0, 1'b0);
        #1;
        check("rel_before", int'(bus.drive_c), 1);
        bus.cs = 1'b0;
        #1;
        check("rel_same_cycle", int'(bus.drive_c), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
